cpu_loader: RTL and testbench
=============================

CPU_LOADER -- requirements
Module: cpu_loader

Interface
REQ-001 SHALL have parameters: IMEM_LEN_W, default 9, imem length width in words; DMEM_LEN_W, default 10, dmem length and dump width in words.
REQ-002 SHALL use one clock and a synchronous, active-high reset, with ports as listed below.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load/run/dump sequence.
REQ-006 imem_len  input  IMEM_LEN_W  number of words to load into instruction memory.
REQ-007 dmem_len  input  DMEM_LEN_W  number of words to load into data memory.
REQ-008 run_cycles  input  16  number of cycles to hold cpu_enable high.
REQ-009 dump_base  input  32  data-memory byte address of the first word to read back.
REQ-010 dump_len  input  DMEM_LEN_W  number of words to read back.
REQ-011 s_valid / s_ready / s_data  input / output / input  1/1/32  load word stream.
REQ-012 m_valid / m_ready / m_data  output / input / output  1/1/32  dump word stream.
REQ-013 cpu_enable  output  1  drives the CPU enable input.
REQ-014 imem_addr / imem_wen / imem_ren / imem_wdata  output  32/1/1/32  instruction-memory external port.
REQ-015 dmem_addr / dmem_wen / dmem_ren / dmem_wdata  output  32/1/1/32  data-memory external port.
REQ-016 dmem_rdata  input  32  data-memory external read data, valid 1 cycle after dmem_ren.
REQ-017 busy / done  output  1/1  sequence in progress / sequence finished.

Function
REQ-018 SHALL implement states IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_CAP, DUMP_OUT, and DONE.
REQ-019 In IDLE or DONE, start SHALL latch all five length/base inputs, clear done, and go to the first non-empty phase in the order LOAD_I, LOAD_D, RUN, DUMP, DONE.
REQ-020 start while busy SHALL be ignored, and latched values SHALL not change.
REQ-021 s_ready SHALL be 1 only in LOAD_I/LOAD_D; a word SHALL be accepted when s_valid and s_ready are both 1.
REQ-022 Each accepted word SHALL produce a registered write on the next cycle: *_wen=1 for exactly 1 cycle, *_addr=4*index, *_wdata=the word, with the index starting at 0 per memory.
REQ-023 LOAD_I SHALL exit after imem_len accepts, and LOAD_D SHALL exit after dmem_len accepts.
REQ-024 The last write strobe SHALL still issue in the cycle after the exit.
REQ-025 RUN SHALL assert cpu_enable for exactly run_cycles consecutive cycles.
REQ-026 cpu_enable SHALL be 0 in every other state, and all *_wen/*_ren SHALL be 0 during RUN.
REQ-027 DUMP_RD SHALL assert dmem_ren=1 for 1 cycle with dmem_addr=dump_base+4*k, where k is the word index.
REQ-028 DUMP_CAP SHALL register dmem_rdata into the m_data buffer.
REQ-029 DUMP_OUT SHALL hold m_valid=1 and a stable m_data until m_ready; on that handshake it SHALL increment k and go to DUMP_RD, or to DONE after dump_len words.
REQ-030 Address arithmetic SHALL be 32-bit modulo 2^32, and dump_base+4*k SHALL wrap silently.
REQ-031 A zero value for any length or for run_cycles SHALL skip that phase with no strobes and no cpu_enable pulse.
REQ-032 busy SHALL be 1 in all states except IDLE and DONE.
REQ-033 done SHALL be 1 in DONE and held there until the next start or rst.
REQ-034 Stalls on s_valid=0 or m_ready=0 SHALL not lose, duplicate, or reorder words.
REQ-035 imem_ren SHALL stay 0 at all times, and imem and dmem SHALL never be strobed in the same cycle.

Reset
REQ-036 rst=1 SHALL, at the next rising edge, force IDLE and clear every counter and latched value.
REQ-037 After that edge, cpu_enable, busy, done, s_ready, m_valid, every *_wen/*_ren, and every address/data output SHALL be 0.
REQ-038 rst mid-sequence SHALL abort with no further strobe; a write strobe registered before the edge SHALL not appear after it.

Verification
REQ-039 Load: start with imem_len=3, dmem_len=2, run=0, dump=0, and words A,B,C,D,E -> imem writes A/0,B/4,C/8, dmem writes D/0,E/4, then done=1.
REQ-040 Run: start with all lengths 0 and run_cycles=5 -> cpu_enable high for exactly 5 cycles, no memory strobes, then done.
REQ-041 Dump with backpressure: dump_base=0x10, dump_len=2, with m_ready low for 3 cycles -> dmem_ren at 0x10 then 0x14, m_data stable while stalled, two words out in order.
REQ-042 Wrap: dump_base=0xFFFFFFFC, dump_len=2 -> read addresses 0xFFFFFFFC then 0x00000000.
REQ-043 Reset and ignored start: rst during LOAD_D after 1 of 4 words -> outputs 0 next cycle and no further strobes; start mid-RUN -> no effect.

Source files
------------

// File: rtl/cpu_loader.sv
// Host-side sequencer around a CPU: it streams words into instruction and data memory,
// enables the CPU for a fixed number of cycles, then streams a window of data memory back out.
module cpu_loader #(
    parameter int IMEM_LEN_W = 9,
    parameter int DMEM_LEN_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IMEM_LEN_W-1:0] imem_len,
    input  logic [DMEM_LEN_W-1:0] dmem_len,
    input  logic [15:0]           run_cycles,
    input  logic [31:0]           dump_base,
    input  logic [DMEM_LEN_W-1:0] dump_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [31:0]           s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [31:0]           m_data,
    output logic                  cpu_enable,
    output logic [31:0]           imem_addr,
    output logic                  imem_wen,
    output logic                  imem_ren,
    output logic [31:0]           imem_wdata,
    output logic [31:0]           dmem_addr,
    output logic                  dmem_wen,
    output logic                  dmem_ren,
    output logic [31:0]           dmem_wdata,
    input  logic [31:0]           dmem_rdata,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD_I, ST_LOAD_D, ST_RUN,
        ST_DUMP_RD, ST_DUMP_CAP, ST_DUMP_OUT, ST_DONE
    } state_t;

    // First non-empty phase among those still ahead; DONE when nothing is left.
    function automatic state_t first_phase(input logic i_ne, input logic d_ne,
                                           input logic r_ne, input logic u_ne);
        if (i_ne)      return ST_LOAD_I;
        else if (d_ne) return ST_LOAD_D;
        else if (r_ne) return ST_RUN;
        else if (u_ne) return ST_DUMP_RD;
        else           return ST_DONE;
    endfunction

    state_t                state_q, state_d;
    logic [IMEM_LEN_W-1:0] imem_len_q;
    logic [DMEM_LEN_W-1:0] dmem_len_q;
    logic [15:0]           run_cycles_q;
    logic [31:0]           dump_base_q;
    logic [DMEM_LEN_W-1:0] dump_len_q;
    logic [15:0]           cnt_q, cnt_d;
    logic                  imem_wen_q, dmem_wen_q;
    logic [31:0]           imem_addr_q, imem_wdata_q;
    logic [31:0]           dmem_addr_q, dmem_wdata_q;
    logic [31:0]           m_data_q;

    logic        accept;
    logic        start_ok;
    logic        wr_pending;
    logic        step;
    logic        last_beat;
    logic [15:0] limit;
    logic [31:0] beat_addr;
    logic [31:0] dump_addr;

    assign start_ok   = start && !busy;
    assign accept     = s_valid && s_ready;
    // A trailing load write may still be in flight on entry to RUN or DUMP_RD; hold one cycle.
    assign wr_pending = imem_wen_q || dmem_wen_q;
    assign step       = accept || cpu_enable || (m_valid && m_ready);
    assign beat_addr  = 32'({cnt_q, 2'b00});
    assign dump_addr  = dump_base_q + beat_addr;
    assign last_beat  = (cnt_q + 16'd1) == limit;

    always_comb begin
        limit = 16'd0;
        case (state_q)
            ST_LOAD_I:   limit = 16'(imem_len_q);
            ST_LOAD_D:   limit = 16'(dmem_len_q);
            ST_RUN:      limit = run_cycles_q;
            ST_DUMP_OUT: limit = 16'(dump_len_q);
            default:     limit = 16'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = first_phase(imem_len != '0, dmem_len != '0,
                                          run_cycles != '0, dump_len != '0);
                end
            end
            ST_LOAD_I: begin
                if (accept && last_beat) begin
                    state_d = first_phase(1'b0, dmem_len_q != '0,
                                          run_cycles_q != '0, dump_len_q != '0);
                end
            end
            ST_LOAD_D: begin
                if (accept && last_beat) begin
                    state_d = first_phase(1'b0, 1'b0, run_cycles_q != '0, dump_len_q != '0);
                end
            end
            ST_RUN: begin
                if (cpu_enable && last_beat) begin
                    state_d = first_phase(1'b0, 1'b0, 1'b0, dump_len_q != '0);
                end
            end
            ST_DUMP_RD: begin
                if (!wr_pending) state_d = ST_DUMP_CAP;
            end
            ST_DUMP_CAP: state_d = ST_DUMP_OUT;
            ST_DUMP_OUT: begin
                if (m_ready) state_d = last_beat ? ST_DONE : ST_DUMP_RD;
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_ok) begin
            cnt_d = 16'd0;
        end else if (step) begin
            cnt_d = last_beat ? 16'd0 : cnt_q + 16'd1;
        end
    end

    always_comb begin
        s_ready    = (state_q == ST_LOAD_I) || (state_q == ST_LOAD_D);
        cpu_enable = (state_q == ST_RUN) && !wr_pending;
        dmem_ren   = (state_q == ST_DUMP_RD) && !wr_pending;
        m_valid    = (state_q == ST_DUMP_OUT);
        busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done       = (state_q == ST_DONE);
        dmem_addr  = dmem_ren ? dump_addr : dmem_addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imem_len_q   <= '0;
            dmem_len_q   <= '0;
            run_cycles_q <= '0;
            dump_base_q  <= '0;
            dump_len_q   <= '0;
            cnt_q        <= '0;
            imem_wen_q   <= 1'b0;
            dmem_wen_q   <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            m_data_q     <= '0;
        end else begin
            imem_wen_q <= accept && (state_q == ST_LOAD_I);
            dmem_wen_q <= accept && (state_q == ST_LOAD_D);
            if (accept) begin
                if (state_q == ST_LOAD_I) begin
                    imem_addr_q  <= beat_addr;
                    imem_wdata_q <= s_data;
                end else begin
                    dmem_addr_q  <= beat_addr;
                    dmem_wdata_q <= s_data;
                end
            end
            if (state_q == ST_DUMP_CAP) m_data_q <= dmem_rdata;
            if (start_ok) begin
                imem_len_q   <= imem_len;
                dmem_len_q   <= dmem_len;
                run_cycles_q <= run_cycles;
                dump_base_q  <= dump_base;
                dump_len_q   <= dump_len;
            end
            cnt_q <= cnt_d;
        end
    end

    assign imem_wen   = imem_wen_q;
    assign imem_ren   = 1'b0;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign dmem_wen   = dmem_wen_q;
    assign dmem_wdata = dmem_wdata_q;
    assign m_data     = m_data_q;

endmodule

// File: tb/tb_cpu_loader.sv
// Self-checking bench for cpu_loader: a vector table of sequences driven with random stalls
// and compared against expectations derived from lengths, bases and the source word list.
module tb_cpu_loader;
    localparam int IW = 9;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [IW-1:0] imem_len;
    logic [DW-1:0] dmem_len, dump_len;
    logic [15:0]   run_cycles;
    logic [31:0]   dump_base;
    logic          s_valid, s_ready, m_valid, m_ready;
    logic [31:0]   s_data, m_data;
    logic          cpu_enable, imem_wen, imem_ren, dmem_wen, dmem_ren, busy, done;
    logic [31:0]   imem_addr, imem_wdata, dmem_addr, dmem_wdata, dmem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_loader #(.IMEM_LEN_W(IW), .DMEM_LEN_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_len(imem_len), .dmem_len(dmem_len), .run_cycles(run_cycles),
        .dump_base(dump_base), .dump_len(dump_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .cpu_enable(cpu_enable),
        .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_ren(imem_ren), .imem_wdata(imem_wdata),
        .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_ren(dmem_ren), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .busy(busy), .done(done)
    );

    // Data memory contents are a fixed hash of the byte address.
    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    always @(posedge clk) dmem_rdata <= dmem_ren ? rd_fn(dmem_addr) : $urandom;

    typedef struct {
        int          ilen;
        int          dlen;
        int          rc;
        logic [31:0] dbase;
        int          dnum;
        int          stall_pct;
        bit          stall3;
        int          poke;
        logic [31:0] exp_last_rd;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, 32'({cpu_enable, busy, done, s_ready, m_valid,
                                   imem_wen, imem_ren, dmem_wen, dmem_ren}), 32'd0);
        check({tag, "_imem_addr"}, imem_addr, 32'd0);
        check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        check({tag, "_dmem_addr"}, dmem_addr, 32'd0);
        check({tag, "_dmem_wdata"}, dmem_wdata, 32'd0);
        check({tag, "_m_data"}, m_data, 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] words[$];
        logic [31:0] iw_a[$], iw_d[$], dw_a[$], dw_d[$], rd_a[$], m_d[$];
        int          ptr, en_cnt, rises, viol, stall_cnt, cyc;
        bit          prev_en, prev_stall, fin;
        logic [31:0] prev_md;
        int          n_words;
        n_words = v.ilen + v.dlen;
        for (int i = 0; i < n_words; i++) words.push_back($urandom);
        ptr = 0; en_cnt = 0; rises = 0; viol = 0; stall_cnt = 0;
        prev_en = 1'b0; prev_stall = 1'b0; fin = 1'b0; prev_md = '0;

        imem_len = IW'(v.ilen); dmem_len = DW'(v.dlen); run_cycles = 16'(v.rc);
        dump_base = v.dbase; dump_len = DW'(v.dnum);
        start = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        imem_len = IW'($urandom); dmem_len = DW'($urandom); run_cycles = 16'($urandom);
        dump_base = $urandom; dump_len = DW'($urandom);

        for (cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (imem_wen) begin iw_a.push_back(imem_addr); iw_d.push_back(imem_wdata); end
            if (dmem_wen) begin dw_a.push_back(dmem_addr); dw_d.push_back(dmem_wdata); end
            if (dmem_ren) rd_a.push_back(dmem_addr);
            if (cpu_enable) en_cnt++;
            if (cpu_enable && !prev_en) rises++;
            prev_en = cpu_enable;
            if (imem_ren) viol++;
            if (imem_wen && (dmem_wen || dmem_ren)) viol++;
            if (cpu_enable && (imem_wen || dmem_wen || dmem_ren)) viol++;
            if (m_valid && prev_stall && m_data !== prev_md) viol++;

            if (done) begin
                fin = 1'b1;
            end else begin
                if (s_ready && ptr < n_words && $urandom_range(99) >= 32'(v.stall_pct)) begin
                    s_valid = 1'b1; s_data = words[ptr]; ptr++;
                end else begin
                    s_valid = !s_ready && ($urandom_range(1) == 1);
                    s_data  = $urandom;
                end
                if (m_valid) begin
                    if (v.stall3 && stall_cnt < 3) begin
                        m_ready = 1'b0; stall_cnt++;
                    end else begin
                        m_ready = ($urandom_range(99) >= 32'(v.stall_pct));
                    end
                    if (m_ready) begin m_d.push_back(m_data); stall_cnt = 0; end
                end else begin
                    m_ready = ($urandom_range(1) == 1);
                end
                prev_stall = m_valid && !m_ready;
                prev_md    = m_data;
                if (v.poke != 0 && cyc == v.poke && busy) begin
                    start = 1'b1; imem_len = IW'(5); dmem_len = DW'(3); run_cycles = 16'd7;
                    dump_len = DW'(4);
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        s_valid = 1'b0; m_ready = 1'b0; start = 1'b0;

        check("done_reached", 32'(done), 32'd1);
        check("imem_wr_count", 32'(iw_a.size()), 32'(v.ilen));
        for (int i = 0; i < iw_a.size() && i < v.ilen; i++) begin
            check("imem_addr", iw_a[i], 32'(4 * i));
            check("imem_wdata", iw_d[i], words[i]);
        end
        check("dmem_wr_count", 32'(dw_a.size()), 32'(v.dlen));
        for (int j = 0; j < dw_a.size() && j < v.dlen; j++) begin
            check("dmem_addr", dw_a[j], 32'(4 * j));
            check("dmem_wdata", dw_d[j], words[v.ilen + j]);
        end
        check("rd_count", 32'(rd_a.size()), 32'(v.dnum));
        for (int k = 0; k < rd_a.size() && k < v.dnum; k++)
            check("rd_addr", rd_a[k], v.dbase + 32'(4 * k));
        if (v.dnum > 0 && rd_a.size() > 0)
            check("last_rd_addr", rd_a[rd_a.size() - 1], v.exp_last_rd);
        check("m_count", 32'(m_d.size()), 32'(v.dnum));
        for (int k = 0; k < m_d.size() && k < v.dnum; k++)
            check("m_data", m_d[k], rd_fn(v.dbase + 32'(4 * k)));
        check("en_cycles", 32'(en_cnt), 32'(v.rc));
        check("en_pulses", 32'(rises), (v.rc > 0) ? 32'd1 : 32'd0);
        check("invariants", 32'(viol), 32'd0);
        repeat (3) @(negedge clk);
        check("done_held", 32'(done), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        $display("vec %0d: ilen=%0d dlen=%0d run=%0d base=%08h dump=%0d cycles=%0d",
                 idx, v.ilen, v.dlen, v.rc, v.dbase, v.dnum, cyc);
    endtask

    initial begin
        int          quiet;
        logic [31:0] w0, w1;

        vecs[0] = '{3, 2, 0, 32'h0, 0, 20, 1'b0, 0, 32'h0};
        vecs[1] = '{0, 0, 5, 32'h0, 0, 0, 1'b0, 0, 32'h0};
        vecs[2] = '{0, 0, 0, 32'h10, 2, 0, 1'b1, 0, 32'h14};
        vecs[3] = '{0, 0, 0, 32'hFFFF_FFFC, 2, 0, 1'b0, 0, 32'h0};
        vecs[4] = '{0, 0, 0, 32'h0, 0, 0, 1'b0, 0, 32'h0};
        vecs[5] = '{0, 0, 20, 32'h0, 0, 0, 1'b0, 5, 32'h0};
        vecs[6] = '{0, 2, 0, 32'h8, 2, 0, 1'b0, 0, 32'hC};
        vecs[7] = '{1, 0, 0, 32'h40, 1, 0, 1'b0, 0, 32'h40};
        for (int i = 8; i < 20; i++) begin
            vecs[i].ilen      = int'($urandom_range(6));
            vecs[i].dlen      = int'($urandom_range(6));
            vecs[i].rc        = int'($urandom_range(8));
            vecs[i].dbase     = $urandom;
            vecs[i].dnum      = int'($urandom_range(5));
            vecs[i].stall_pct = int'($urandom_range(50));
            vecs[i].stall3    = 1'b0;
            vecs[i].poke      = int'($urandom_range(12));
            vecs[i].exp_last_rd = (vecs[i].dnum > 0) ?
                vecs[i].dbase + 32'(4 * (vecs[i].dnum - 1)) : 32'h0;
        end

        // Reset with start asserted and junk inputs: reset must dominate.
        rst = 1'b1; start = 1'b1; s_valid = 1'b1; s_data = $urandom; m_ready = 1'b1;
        imem_len = IW'(3); dmem_len = DW'(3); run_cycles = 16'd3; dump_base = 32'h100;
        dump_len = DW'(3);
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0; start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 20; i++) run_vec(i, vecs[i]);

        // Reset in LOAD_D after one of four words, on the very edge that accepts the second.
        w0 = $urandom; w1 = $urandom;
        imem_len = '0; dmem_len = DW'(4); run_cycles = '0; dump_base = '0; dump_len = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rstseq_s_ready", 32'(s_ready), 32'd1);
        s_valid = 1'b1; s_data = w0;
        @(negedge clk);
        check("rstseq_wen", 32'(dmem_wen), 32'd1);
        check("rstseq_addr", dmem_addr, 32'd0);
        check("rstseq_wdata", dmem_wdata, w0);
        s_data = w1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("midrst");
        quiet = 0;
        repeat (8) begin
            @(negedge clk);
            if (imem_wen || dmem_wen || dmem_ren || busy || s_ready || cpu_enable) quiet++;
        end
        s_valid = 1'b0;
        check("post_rst_quiet", 32'(quiet), 32'd0);
        $display("rst_seq: reset during LOAD_D after 1 of 4 words, %0d stray cycles", quiet);

        run_vec(20, vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
